// File: rtl/game_pkg.sv
// Shared game-wide types and constants used by the enemy formation logic.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_WAIT,
    ST_MOVE,
    ST_SCAN,
    ST_CHECK
  } squad_state_t;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned bounding-box overlap test between box 1 (W1 x H1)
// and box 2 (W2 x H2). Sums are widened to 11 bits so edges near 1023 cannot wrap.
module aabb_overlap #(
  parameter int W1 = 16,
  parameter int H1 = 16,
  parameter int W2 = 8,
  parameter int H2 = 8
) (
  input  logic [9:0] x1,
  input  logic [9:0] y1,
  input  logic [9:0] x2,
  input  logic [9:0] y2,
  output logic       hit
);

  logic [10:0] x1w, y1w, x2w, y2w;

  assign x1w = {1'b0, x1};
  assign y1w = {1'b0, y1};
  assign x2w = {1'b0, x2};
  assign y2w = {1'b0, y2};

  assign hit = (x2w < x1w + 11'(W1)) && (x2w + 11'(W2) > x1w) &&
               (y2w < y1w + 11'(H1)) && (y2w + 11'(H2) > y1w);

endmodule

// File: rtl/enemy_squad_controller.sv
// Enemy formation controller: sweep-and-drop movement once per frame, then a
// serial enemy x bullet collision scan, one pair per cycle.
// Optional build macro: HIT_FLASH_EN (per-enemy hit-flash counters).
module enemy_squad_controller
  import game_pkg::*;
#(
  parameter int ENEMY_COUNT  = 8,
  parameter int BULLET_COUNT = 8,
  parameter int ENEMY_W      = 16,
  parameter int ENEMY_H      = 16,
  parameter int BULLET_W     = 8,
  parameter int BULLET_H     = 8,
  parameter int HP_INIT      = 3,
  parameter int STEP_X       = 2,
  parameter int STEP_Y       = 8,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 640,
  parameter int Y_START      = 40,
  parameter int Y_MAX        = 440,
  parameter int FORMATION_DX = 40
) (
  input  logic                      clk25,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      start,
  input  logic                      frame_tick,
  input  logic [10*BULLET_COUNT-1:0] bullet_x_flat,
  input  logic [10*BULLET_COUNT-1:0] bullet_y_flat,
  input  logic [BULLET_COUNT-1:0]   bullet_active_flat,
  output logic [10*ENEMY_COUNT-1:0] enemy_x_flat,
  output logic [10*ENEMY_COUNT-1:0] enemy_y_flat,
  output logic [ENEMY_COUNT-1:0]    enemy_alive,
  output logic [ENEMY_COUNT-1:0]    enemy_flash,
  output logic [BULLET_COUNT-1:0]   bullet_hit,
  output logic [ENEMY_COUNT-1:0]    enemy_killed,
  output logic                      wave_clear,
  output logic                      breached
);

  localparam int EIW = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;
  localparam int BIW = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;

  squad_state_t state, state_nx;
  dir_t         dir;

  logic [9:0] ex [ENEMY_COUNT];
  logic [9:0] ey [ENEMY_COUNT];
  logic [3:0] hp [ENEMY_COUNT];

  logic [BULLET_COUNT-1:0] consumed;
  logic [EIW-1:0]          e_idx;
  logic [BIW-1:0]          b_idx;
  logic                    pending_tick;

  logic       bound_hit, breach_hit;
  logic [9:0] cur_bx, cur_by;
  logic       overlap, pair_hit, kill_now, last_pair, frame_go;

  // Saturating drop of one row; Y_MAX is the breach row and the floor.
  function automatic logic [9:0] drop_y(input logic [9:0] y);
    logic [10:0] s;
    s = {1'b0, y} + 11'(STEP_Y);
    return (s > 11'(Y_MAX)) ? 10'(Y_MAX) : s[9:0];
  endfunction

  // Bound test over live enemies and breach test for the row after a drop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    bound_hit  = 1'b0;
    breach_hit = 1'b0;
    for (int i = 0; i < ENEMY_COUNT; i++) begin
      if (enemy_alive[i]) begin
        if (dir == DIR_RIGHT) begin
          if ({1'b0, ex[i]} + 11'(ENEMY_W + STEP_X) > 11'(X_MAX)) bound_hit = 1'b1;
        end else begin
          if ({1'b0, ex[i]} < 11'(X_MIN + STEP_X)) bound_hit = 1'b1;
        end
        if (drop_y(ey[i]) == 10'(Y_MAX)) breach_hit = 1'b1;
      end
    end
  end

  assign cur_bx = bullet_x_flat[10*int'(b_idx) +: 10];
  assign cur_by = bullet_y_flat[10*int'(b_idx) +: 10];

  aabb_overlap #(
    .W1(ENEMY_W), .H1(ENEMY_H), .W2(BULLET_W), .H2(BULLET_H)
  ) u_overlap (
    .x1 (ex[e_idx]),
    .y1 (ey[e_idx]),
    .x2 (cur_bx),
    .y2 (cur_by),
    .hit(overlap)
  );

  assign pair_hit  = enemy_alive[e_idx] && bullet_active_flat[b_idx] &&
                     !consumed[b_idx] && overlap;
  assign kill_now  = pair_hit && (hp[e_idx] == 4'd1);
  assign last_pair = (e_idx == EIW'(ENEMY_COUNT - 1)) && (b_idx == BIW'(BULLET_COUNT - 1));
  assign frame_go  = enable && (frame_tick || pending_tick);

  // State register.
  always_ff @(posedge clk25) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; start overrides everything.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = ST_SPAWN;
    end else begin
      case (state)
        ST_IDLE:  state_nx = ST_IDLE;
        ST_SPAWN: state_nx = ST_WAIT;
        ST_WAIT:  if (frame_go) state_nx = ST_MOVE;
        ST_MOVE:  if (enable) state_nx = ST_SCAN;
        ST_SCAN:  if (enable && last_pair) state_nx = ST_CHECK;
        ST_CHECK: state_nx = (enemy_alive == '0) ? ST_IDLE : ST_WAIT;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Formation datapath: spawn, movement, collision scan and the output pulses.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      // NOTE: these per-enemy arrays are small flop banks, not RAM, so they take a reset.
      for (int i = 0; i < ENEMY_COUNT; i++) begin
        ex[i] <= '0;
        ey[i] <= '0;
        hp[i] <= '0;
      end
      enemy_alive  <= '0;
      bullet_hit   <= '0;
      enemy_killed <= '0;
      wave_clear   <= 1'b0;
      breached     <= 1'b0;
      dir          <= DIR_RIGHT;
      pending_tick <= 1'b0;
      consumed     <= '0;
      e_idx        <= '0;
      b_idx        <= '0;
    end else begin
      // NOTE: non-blocking throughout; the pulse defaults here are overridden by later writes.
      bullet_hit   <= '0;
      enemy_killed <= '0;
      wave_clear   <= 1'b0;

      if (frame_tick && (state inside {ST_MOVE, ST_SCAN, ST_CHECK}))
        pending_tick <= 1'b1;

      if (!start) begin
        case (state)
          ST_SPAWN: begin
            for (int i = 0; i < ENEMY_COUNT; i++) begin
              ex[i] <= 10'(X_MIN + i * FORMATION_DX);
              ey[i] <= 10'(Y_START);
              hp[i] <= 4'(HP_INIT);
            end
            enemy_alive  <= '1;
            dir          <= DIR_RIGHT;
            breached     <= 1'b0;
            pending_tick <= 1'b0;
          end
          ST_WAIT: begin
            if (frame_go) pending_tick <= 1'b0;
          end
          ST_MOVE: begin
            if (enable) begin
              consumed <= '0;
              e_idx    <= '0;
              b_idx    <= '0;
              if (bound_hit) begin
                dir <= (dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
                for (int i = 0; i < ENEMY_COUNT; i++) ey[i] <= drop_y(ey[i]);
                if (breach_hit) breached <= 1'b1;
              end else begin
                for (int i = 0; i < ENEMY_COUNT; i++)
                  ex[i] <= (dir == DIR_RIGHT) ? ex[i] + 10'(STEP_X) : ex[i] - 10'(STEP_X);
              end
            end
          end
          ST_SCAN: begin
            if (enable) begin
              if (pair_hit) begin
                hp[e_idx]         <= hp[e_idx] - 4'd1;
                consumed[b_idx]   <= 1'b1;
                bullet_hit[b_idx] <= 1'b1;
                if (kill_now) begin
                  enemy_alive[e_idx]  <= 1'b0;
                  enemy_killed[e_idx] <= 1'b1;
                end
              end
              if (b_idx == BIW'(BULLET_COUNT - 1)) begin
                b_idx <= '0;
                if (e_idx != EIW'(ENEMY_COUNT - 1)) e_idx <= e_idx + 1'b1;
              end else begin
                b_idx <= b_idx + 1'b1;
              end
            end
          end
          ST_CHECK: begin
            if (enemy_alive == '0) wave_clear <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef HIT_FLASH_EN
  logic [2:0] flash_cnt [ENEMY_COUNT];

  // Hit-flash counters: load on a non-lethal hit, count down once per moved frame.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      for (int i = 0; i < ENEMY_COUNT; i++) flash_cnt[i] <= '0;
    end else if (!start) begin
      if (state == ST_SPAWN) begin
        for (int i = 0; i < ENEMY_COUNT; i++) flash_cnt[i] <= '0;
      end else if (state == ST_MOVE && enable) begin
        for (int i = 0; i < ENEMY_COUNT; i++)
          if (flash_cnt[i] != 3'd0) flash_cnt[i] <= flash_cnt[i] - 3'd1;
      end else if (state == ST_SCAN && enable && pair_hit && !kill_now) begin
        flash_cnt[e_idx] <= 3'd7;
      end
    end
  end

  // Flash only while the enemy is still alive.
  always_comb begin
    enemy_flash = '0;
    for (int i = 0; i < ENEMY_COUNT; i++)
      enemy_flash[i] = (flash_cnt[i] != 3'd0) && enemy_alive[i];
  end
`else
  assign enemy_flash = '0;
`endif

  // Flatten per-enemy positions onto the output buses.
  always_comb begin
    enemy_x_flat = '0;
    enemy_y_flat = '0;
    for (int i = 0; i < ENEMY_COUNT; i++) begin
      enemy_x_flat[10*i +: 10] = ex[i];
      enemy_y_flat[10*i +: 10] = ey[i];
    end
  end

endmodule

// File: tb/tb_enemy_squad_controller.sv
// Directed, table-driven bench for enemy_squad_controller. A second instance with
// a tight formation and small playfield covers the overlap and breach corners.
module tb_enemy_squad_controller;

  localparam int E = 8;
  localparam int B = 8;

  logic clk25 = 1'b0;
  logic rst_n, enable, start, start2, frame_tick;
  logic [10*B-1:0] bullet_x_flat, bullet_y_flat;
  logic [B-1:0]    bullet_active_flat;

  logic [10*E-1:0] ex1, ey1, ex2, ey2;
  logic [E-1:0]    alive1, flash1, killed1, alive2, flash2, killed2;
  logic [B-1:0]    hit1, hit2;
  logic            wc1, wc2, breached1, breached2;

  int checks = 0;
  int errors = 0;

  // Pulse accumulators since the last clear_acc().
  logic [B-1:0] acc_hit1, acc_hit2;
  logic [E-1:0] acc_kill1, acc_kill2;
  int           acc_cnt1, acc_cnt2, acc_wc1;

  typedef struct {
    int         bidx;
    int         bx;
    int         by;
    logic       act;
    logic [7:0] exp_hit;
  } vec_t;

  vec_t vecs [13];

  always #20 clk25 = ~clk25;

  enemy_squad_controller dut (
    .clk25(clk25), .rst_n(rst_n), .enable(enable), .start(start), .frame_tick(frame_tick),
    .bullet_x_flat(bullet_x_flat), .bullet_y_flat(bullet_y_flat),
    .bullet_active_flat(bullet_active_flat),
    .enemy_x_flat(ex1), .enemy_y_flat(ey1), .enemy_alive(alive1), .enemy_flash(flash1),
    .bullet_hit(hit1), .enemy_killed(killed1), .wave_clear(wc1), .breached(breached1)
  );

  enemy_squad_controller #(.FORMATION_DX(12), .X_MAX(120), .Y_MAX(56)) dut2 (
    .clk25(clk25), .rst_n(rst_n), .enable(enable), .start(start2), .frame_tick(frame_tick),
    .bullet_x_flat(bullet_x_flat), .bullet_y_flat(bullet_y_flat),
    .bullet_active_flat(bullet_active_flat),
    .enemy_x_flat(ex2), .enemy_y_flat(ey2), .enemy_alive(alive2), .enemy_flash(flash2),
    .bullet_hit(hit2), .enemy_killed(killed2), .wave_clear(wc2), .breached(breached2)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] fx(input logic [79:0] f, input int i);
    logic [9:0] v;
    v = f[10*i +: 10];
    return {70'd0, v};
  endfunction

  task automatic clear_acc();
    acc_hit1 = '0; acc_hit2 = '0; acc_kill1 = '0; acc_kill2 = '0;
    acc_cnt1 = 0;  acc_cnt2 = 0;  acc_wc1 = 0;
  endtask

  // Advance n cycles; sample 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk25);
      #1;
      acc_hit1  |= hit1;
      acc_hit2  |= hit2;
      acc_kill1 |= killed1;
      acc_kill2 |= killed2;
      acc_cnt1  += $countones(hit1);
      acc_cnt2  += $countones(hit2);
      acc_wc1   += int'(wc1);
    end
  endtask

  // One frame: tick pulse, then enough cycles for MOVE + 64 pairs + CHECK.
  task automatic frame();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(71);
  endtask

  task automatic spawn1();
    start = 1'b1; step(1); start = 1'b0; step(1);
  endtask

  task automatic set_bullet(input int idx, input int x, input int y, input logic act);
    bullet_x_flat[10*idx +: 10] = 10'(x);
    bullet_y_flat[10*idx +: 10] = 10'(y);
    bullet_active_flat[idx]     = act;
  endtask

  task automatic clear_bullets();
    bullet_x_flat = '0; bullet_y_flat = '0; bullet_active_flat = '0;
  endtask

  initial begin
    logic [79:0] exp_x, exp_y;

    // Collision geometry around enemy 0 at (2,40) and its neighbours, after one move.
    vecs[0]  = '{0,  10, 44, 1'b1, 8'h01};
    vecs[1]  = '{0,  17, 44, 1'b1, 8'h01};
    vecs[2]  = '{0,  18, 44, 1'b1, 8'h00};
    vecs[3]  = '{0,   0, 44, 1'b1, 8'h01};
    vecs[4]  = '{0,  10, 32, 1'b1, 8'h00};
    vecs[5]  = '{0,  10, 33, 1'b1, 8'h01};
    vecs[6]  = '{0,  10, 55, 1'b1, 8'h01};
    vecs[7]  = '{0,  10, 56, 1'b1, 8'h00};
    vecs[8]  = '{0,  10, 44, 1'b0, 8'h00};
    vecs[9]  = '{5,  45, 44, 1'b1, 8'h20};
    vecs[10] = '{7, 290, 44, 1'b1, 8'h80};
    vecs[11] = '{2,  34, 44, 1'b1, 8'h00};
    vecs[12] = '{2,  35, 44, 1'b1, 8'h04};

    rst_n = 1'b0; enable = 1'b1; start = 1'b0; start2 = 1'b0; frame_tick = 1'b0;
    clear_bullets();
    clear_acc();
    step(3);
    check("rst_alive",    80'(alive1), 80'h0);
    check("rst_x",        ex1, 80'h0);
    check("rst_y",        ey1, 80'h0);
    check("rst_breached", 80'(breached1), 80'h0);
    check("rst_pulses",   80'({hit1, killed1, wc1, flash1}), 80'h0);
    check("rst_alive2",   80'(alive2), 80'h0);

    rst_n = 1'b1;
    step(2);
    frame();
    check("idle_ignores_tick", ex1, 80'h0);

    spawn1();
    check("spawn_x3",     fx(ex1, 3), 80'd120);
    check("spawn_y3",     fx(ey1, 3), 80'd40);
    check("spawn_alive",  80'(alive1), 80'hFF);
    check("spawn_breach", 80'(breached1), 80'h0);

    // Tick latency: position changes on the second edge after the tick.
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    check("lat_cycle1_x3", fx(ex1, 3), 80'd120);
    step(1);
    check("lat_cycle2_x3", fx(ex1, 3), 80'd122);
    step(70);

    // Enable low in WAIT: tick ignored and not remembered.
    spawn1();
    enable = 1'b0;
    frame();
    enable = 1'b1;
    step(72);
    check("enable_low_no_move", fx(ex1, 3), 80'd120);

    // Right bound: enemy 7 from 280 reaches 624 after 172 frames, then drops.
    spawn1();
    for (int k = 0; k < 172; k++) frame();
    check("bound_x7_172", fx(ex1, 7), 80'd624);
    check("bound_y7_172", fx(ey1, 7), 80'd40);
    frame();
    check("drop_x7_173", fx(ex1, 7), 80'd624);
    check("drop_y7_173", fx(ey1, 7), 80'd48);
    check("drop_x0_173", fx(ex1, 0), 80'd344);
    frame();
    check("left_x7_174", fx(ex1, 7), 80'd622);

    // Table-driven collision vectors, fresh wave for each.
    for (int v = 0; v < 13; v++) begin
      spawn1();
      clear_bullets();
      set_bullet(vecs[v].bidx, vecs[v].bx, vecs[v].by, vecs[v].act);
      clear_acc();
      frame();
      check($sformatf("vec%0d_hit", v), 80'(acc_hit1), 80'(vecs[v].exp_hit));
      clear_bullets();
    end

    // Bullet held in enemy 2 for three frames: three hits, kill on the third.
    spawn1();
    set_bullet(1, 88, 44, 1'b1);
    for (int f = 1; f <= 3; f++) begin
      clear_acc();
      frame();
      check($sformatf("kill2_f%0d_hit", f),  80'(acc_hit1), 80'h02);
      check($sformatf("kill2_f%0d_cnt", f),  80'(acc_cnt1), 80'd1);
      check($sformatf("kill2_f%0d_kill", f), 80'(acc_kill1), (f == 3) ? 80'h04 : 80'h00);
    end
    check("kill2_alive", 80'(alive1), 80'hFB);
    clear_bullets();

    // Two ticks during one scan: exactly one extra move (126 -> 130).
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    step(20);
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    step(10);
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    step(300);
    check("pending_one_extra_move", fx(ex1, 3), 80'd130);

    // Kill the whole wave over three frames.
    spawn1();
    for (int i = 0; i < E; i++) set_bullet(i, 40*i + 10, 44, 1'b1);
    for (int f = 1; f <= 3; f++) begin
      clear_acc();
      frame();
      check($sformatf("wave_f%0d_hit", f), 80'(acc_hit1), 80'hFF);
      check($sformatf("wave_f%0d_wc", f),  80'(acc_wc1), (f == 3) ? 80'd1 : 80'd0);
    end
    check("wave_killed_f3", 80'(acc_kill1), 80'hFF);
    check("wave_alive",     80'(alive1), 80'h00);
    clear_bullets();
    frame();
    frame();
    exp_x = '0;
    exp_y = '0;
    for (int i = 0; i < E; i++) begin
      exp_x[10*i +: 10] = 10'(40*i + 6);
      exp_y[10*i +: 10] = 10'd40;
    end
    check("idle_frozen_x", ex1, exp_x);
    check("idle_frozen_y", ey1, exp_y);

    // Second instance: breach after two drops (y 40 -> 48 -> 56 = Y_MAX).
    start2 = 1'b1; step(1); start2 = 1'b0; step(1);
    for (int k = 0; k < 21; k++) frame();
    check("d2_y0_21",      fx(ey2, 0), 80'd48);
    check("d2_breach_21",  80'(breached2), 80'h0);
    frame();
    check("d2_y0_22",      fx(ey2, 0), 80'd56);
    check("d2_x0_22",      fx(ex2, 0), 80'd0);
    check("d2_breach_22",  80'(breached2), 80'h1);

    // start mid-scan respawns and clears breached.
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    step(20);
    start2 = 1'b1; step(1); start2 = 1'b0; step(1);
    check("d2_respawn_breach", 80'(breached2), 80'h0);
    check("d2_respawn_y0",     fx(ey2, 0), 80'd40);
    check("d2_respawn_x1",     fx(ex2, 1), 80'd12);
    check("d2_respawn_alive",  80'(alive2), 80'hFF);

    // One bullet overlapping enemies 0 and 1: only enemy 0 is hit, dies on the 3rd frame.
    set_bullet(0, 12, 44, 1'b1);
    for (int f = 1; f <= 3; f++) begin
      clear_acc();
      frame();
      check($sformatf("ovl_f%0d_hit", f),  80'(acc_hit2), 80'h01);
      check($sformatf("ovl_f%0d_cnt", f),  80'(acc_cnt2), 80'd1);
      check($sformatf("ovl_f%0d_kill", f), 80'(acc_kill2), (f == 3) ? 80'h01 : 80'h00);
    end
    check("ovl_alive", 80'(alive2), 80'hFE);
    clear_bullets();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
